trigger_unit: RTL and testbench

Parametrised trigger front end for the drift-chamber readout. It selects one of NSRC trigger sources, edge-detects it, applies a programmable dead time and an external busy veto, and emits a 1-clk trigger pulse. It classifies long trigger levels as accelerator cycles (cycleend/cyclebegin pulses, cycleon level) and keeps accepted-trigger, vetoed-trigger and cycle counters for the register file.

---
 rtl/trigger_unit.sv | 140 ++++++++++++++
 tb/tb_trigger_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_unit.sv
`default_nettype none
// trigger_unit: selects one trigger source, edge-detects it, applies dead time and busy veto,
// classifies long levels as accelerator cycles and keeps accepted/vetoed/cycle counters.
module trigger_unit #(
  parameter int NSRC  = 4,
  parameter int SELW  = 2,
  parameter int DEADW = 8,
  parameter int LENW  = 12,
  parameter int CNTW  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  trigsrc,
  input  logic [SELW-1:0]  trigsel,
  input  logic             trigen,
  input  logic             busy,
  input  logic [DEADW-1:0] deadtime,
  input  logic [LENW-1:0]  cyclen,
  input  logic             cntclr,
  output logic             trigpulse,
  output logic             cycleend,
  output logic             cyclebegin,
  output logic             cycleon,
  output logic [CNTW-1:0]  trigcnt,
  output logic [CNTW-1:0]  vetocnt,
  output logic [CNTW-1:0]  cyclecnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CYCLE = 1'b1
  } state_t;

  state_t           state_q;
  logic             trigmux_q;
  logic             trigdly_q;
  logic [DEADW-1:0] deadcnt_q;
  logic [LENW-1:0]  lencnt_q;
  logic             trigpulse_q;
  logic             cycleend_q;
  logic             cyclebegin_q;
  logic [CNTW-1:0]  trigcnt_q,  trigcnt_d;
  logic [CNTW-1:0]  vetocnt_q,  vetocnt_d;
  logic [CNTW-1:0]  cyclecnt_q, cyclecnt_d;

  logic sel_bit;
  logic rise;
  logic dead;
  logic accept;
  logic veto;

  // Select values with no matching source fall through to constant 0.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (trigsel == SELW'(i)) sel_bit = trigsrc[i];
    end
  end

  assign rise   = trigmux_q & ~trigdly_q;
  assign dead   = |deadcnt_q;
  assign accept = rise & trigen & ~busy & ~dead;
  assign veto   = rise & trigen & (busy | dead);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      trigmux_q    <= 1'b0;
      trigdly_q    <= 1'b0;
      deadcnt_q    <= '0;
      lencnt_q     <= '0;
      trigpulse_q  <= 1'b0;
      cycleend_q   <= 1'b0;
      cyclebegin_q <= 1'b0;
    end else begin
      trigmux_q    <= sel_bit;
      trigdly_q    <= trigmux_q;
      trigpulse_q  <= accept;
      cycleend_q   <= 1'b0;
      cyclebegin_q <= 1'b0;

      if (accept) begin
        deadcnt_q <= deadtime;
      end else if (dead) begin
        deadcnt_q <= deadcnt_q - DEADW'(1);
      end

      // Only an accepted rise loads the length counter, so vetoed levels never form a cycle.
      if (!trigmux_q) begin
        lencnt_q <= '0;
        if (state_q == ST_CYCLE) begin
          state_q      <= ST_IDLE;
          cyclebegin_q <= 1'b1;
        end
      end else if (accept) begin
        lencnt_q <= cyclen;
      end else if (lencnt_q == LENW'(1)) begin
        lencnt_q   <= '0;
        state_q    <= ST_CYCLE;
        cycleend_q <= 1'b1;
      end else if (lencnt_q > LENW'(1)) begin
        lencnt_q <= lencnt_q - LENW'(1);
      end
    end
  end

  always_comb begin
    trigcnt_d  = trigcnt_q + CNTW'(trigpulse_q);
    cyclecnt_d = cyclecnt_q + CNTW'(cycleend_q);
    vetocnt_d  = vetocnt_q;
    if (veto && !(&vetocnt_q)) vetocnt_d = vetocnt_q + CNTW'(1);
    if (cntclr) begin
      trigcnt_d  = '0;
      vetocnt_d  = '0;
      cyclecnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trigcnt_q  <= '0;
      vetocnt_q  <= '0;
      cyclecnt_q <= '0;
    end else begin
      trigcnt_q  <= trigcnt_d;
      vetocnt_q  <= vetocnt_d;
      cyclecnt_q <= cyclecnt_d;
    end
  end

  assign trigpulse  = trigpulse_q;
  assign cycleend   = cycleend_q;
  assign cyclebegin = cyclebegin_q;
  assign cycleon    = (state_q == ST_IDLE);
  assign trigcnt    = trigcnt_q;
  assign vetocnt    = vetocnt_q;
  assign cyclecnt   = cyclecnt_q;

endmodule
`default_nettype wire

// File: tb/tb_trigger_unit.sv
`default_nettype none
// Scoreboard bench for trigger_unit: stimulus queues expected pulses (kind, cycle), a monitor pops them.
module tb_trigger_unit;

  localparam int NSRC = 3;
  localparam int SELW = 2;
  localparam int DEADW = 8;
  localparam int LENW = 12;
  localparam int CNTW = 4;

  localparam int K_TRIG = 0;
  localparam int K_END = 1;
  localparam int K_BEGIN = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] trigsrc = '0;
  logic [SELW-1:0] trigsel = 2'd1;
  logic            trigen = 1'b1;
  logic            busy = 1'b0;
  logic [DEADW-1:0] deadtime = 8'd48;
  logic [LENW-1:0] cyclen = '0;
  logic            cntclr = 1'b0;
  logic            trigpulse, cycleend, cyclebegin, cycleon;
  logic [CNTW-1:0] trigcnt, vetocnt, cyclecnt;

  trigger_unit #(.NSRC(NSRC), .SELW(SELW), .DEADW(DEADW), .LENW(LENW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .trigsrc(trigsrc), .trigsel(trigsel), .trigen(trigen),
    .busy(busy), .deadtime(deadtime), .cyclen(cyclen), .cntclr(cntclr),
    .trigpulse(trigpulse), .cycleend(cycleend), .cyclebegin(cyclebegin), .cycleon(cycleon),
    .trigcnt(trigcnt), .vetocnt(vetocnt), .cyclecnt(cyclecnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc) begin
        failures++;
        $display("FAIL pulse_order: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (trigpulse) take(K_TRIG);
    if (cycleend) take(K_END);
    if (cyclebegin) begin
      take(K_BEGIN);
      checks++;
      if (cycleon !== 1'b1) begin
        failures++;
        $display("FAIL cycleon_at_begin: got %0b expected 1", cycleon);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int t, input int v, input int c);
    chk({tag, "_trigcnt"}, int'(trigcnt), t);
    chk({tag, "_vetocnt"}, int'(vetocnt), v);
    chk({tag, "_cyclecnt"}, int'(cyclecnt), c);
  endtask

  // Two 2-clk pulses on source 1, rising d clks apart.
  task automatic two_pulses(input int d, input bit second_ok);
    int n;
    n = cyc;
    trigsrc = 3'b010;
    push(K_TRIG, n + 2);
    tick(2);
    trigsrc = '0;
    tick(d - 2);
    trigsrc = 3'b010;
    if (second_ok) push(K_TRIG, n + d + 2);
    tick(2);
    trigsrc = '0;
    tick(60);
  endtask

  // Level of len clks on source 1 with the current cyclen.
  task automatic level(input int len, input bit trig_ok, input bit end_ok);
    int n;
    n = cyc;
    trigsrc = 3'b010;
    if (trig_ok) push(K_TRIG, n + 2);
    if (end_ok) begin
      push(K_END, n + 2 + int'(cyclen));
      push(K_BEGIN, n + len + 2);
    end
    tick(len);
    trigsrc = '0;
    tick(60);
  endtask

  task automatic pulses(input int count, input logic [NSRC-1:0] src, input bit ok);
    int n;
    for (int i = 0; i < count; i++) begin
      n = cyc;
      trigsrc = src;
      if (ok) push(K_TRIG, n + 2);
      tick(2);
      trigsrc = '0;
      tick(2);
    end
    tick(10);
  endtask

  initial begin
    int n;
    tick(2);
    chk("reset_trigpulse", int'(trigpulse), 0);
    chk("reset_cycleon", int'(cycleon), 1);
    chk_cnt("reset", 0, 0, 0);
    rst = 1'b0;
    tick(3);

    // Single 3-clk pulse.
    n = cyc;
    trigsrc = 3'b010;
    push(K_TRIG, n + 2);
    tick(3);
    trigsrc = '0;
    tick(60);
    chk_cnt("single", 1, 0, 0);

    two_pulses(20, 1'b0);
    chk_cnt("dead20", 2, 1, 0);
    two_pulses(60, 1'b1);
    chk_cnt("dead60", 4, 1, 0);
    two_pulses(48, 1'b0);
    chk_cnt("dead48", 5, 2, 0);
    two_pulses(49, 1'b1);
    chk_cnt("dead49", 7, 2, 0);

    // 400-clk level with cyclen=160.
    cyclen = 12'd160;
    n = cyc;
    trigsrc = 3'b010;
    push(K_TRIG, n + 2);
    push(K_END, n + 162);
    push(K_BEGIN, n + 402);
    tick(200);
    chk("cycleon_mid", int'(cycleon), 0);
    tick(200);
    trigsrc = '0;
    tick(1);
    chk("cycleon_before_begin", int'(cycleon), 0);
    tick(1);
    chk("cycleon_after_begin", int'(cycleon), 1);
    tick(60);
    chk_cnt("cycle400", 8, 2, 1);

    level(160, 1'b1, 1'b0);
    chk_cnt("cycle160", 9, 2, 1);
    level(161, 1'b1, 1'b1);
    chk_cnt("cycle161", 10, 2, 2);

    // Busy veto on the rise of a long level.
    n = cyc;
    busy = 1'b1;
    trigsrc = 3'b010;
    tick(5);
    busy = 1'b0;
    tick(395);
    trigsrc = '0;
    tick(60);
    chk_cnt("busy", 10, 3, 2);

    trigen = 1'b0;
    pulses(1, 3'b010, 1'b0);
    trigen = 1'b1;
    chk_cnt("trigen_low", 10, 3, 2);

    // cntclr coincident with trigpulse.
    n = cyc;
    trigsrc = 3'b010;
    push(K_TRIG, n + 2);
    tick(2);
    cntclr = 1'b1;
    tick(1);
    cntclr = 1'b0;
    trigsrc = '0;
    chk_cnt("cntclr", 0, 0, 0);
    tick(60);

    // Veto saturation and trigger wrap with a 4-bit counter.
    cyclen = '0;
    busy = 1'b1;
    pulses(15, 3'b010, 1'b0);
    chk("veto15", int'(vetocnt), 15);
    pulses(1, 3'b010, 1'b0);
    chk("veto_sat", int'(vetocnt), 15);
    busy = 1'b0;
    deadtime = '0;
    cntclr = 1'b1;
    tick(1);
    cntclr = 1'b0;
    pulses(17, 3'b010, 1'b1);
    chk_cnt("wrap", 1, 0, 0);

    // Reset 100 clks into a cycle.
    deadtime = 8'd48;
    cyclen = 12'd160;
    n = cyc;
    trigsrc = 3'b010;
    push(K_TRIG, n + 2);
    push(K_END, n + 162);
    tick(262);
    chk("pre_reset_cyclecnt", int'(cyclecnt), 1);
    chk("pre_reset_cycleon", int'(cycleon), 0);
    rst = 1'b1;
    tick(2);
    chk("mid_reset_cycleon", int'(cycleon), 1);
    trigsrc = '0;
    tick(3);
    rst = 1'b0;
    tick(10);
    chk("post_reset_cycleon", int'(cycleon), 1);
    chk_cnt("post_reset", 0, 0, 0);

    // Source select: 3 is out of range for NSRC=3.
    trigsel = 2'd3;
    pulses(2, 3'b111, 1'b0);
    chk_cnt("sel3", 0, 0, 0);
    trigsel = 2'd2;
    pulses(1, 3'b100, 1'b1);
    pulses(1, 3'b011, 1'b0);
    tick(60);
    chk_cnt("sel2", 1, 0, 0);

    tick(20);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
